cellram_arbiter: RTL
====================

# cellram_arbiter

Sequencer and arbiter for the 64x64 single-port 1-bit cell RAM in the Life display path. Gives the pixel reader absolute priority during active video. Paces generations by counting frames and pulsing `step` to the update engine. Grants the engine RAM cycles only while a generation is running and the display is idle. Sits between the VGA timing/pixel reader, the generation engine and the RAM macro.

## Interface
- `GEN_FRAMES`, 30: vblank rising edges per generation; legal range 1..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `vblank`  in  1  vertical blanking flag from VGA timing.
- `disp_active`  in  1  pixel reader needs the RAM this cycle (visible area).
- `disp_addr`  in  12  pixel reader address `{row[5:0], col[5:0]}`.
- `disp_data`  out  1  cell value for the display; registered.
- `eng_req`  in  1  engine requests one RAM access.
- `eng_we`  in  1  access is a write.
- `eng_addr`  in  12  engine address.
- `eng_wdata`  in  1  engine write data.
- `eng_done`  in  1  one-cycle pulse: generation finished.
- `eng_gnt`  out  1  access accepted this cycle.
- `eng_rdata`  out  1  engine read data.
- `eng_rvalid`  out  1  `eng_rdata` valid; one cycle.
- `step`  out  1  one-cycle pulse: start a generation.
- `gen_busy`  out  1  high in RUN.
- `ram_addr`  out  12  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  1  RAM write data.
- `ram_rdata`  in  1  RAM read data; 1-cycle synchronous latency.

## Operation
- FSM states:
  - WAIT: counts frames; engine never granted.
  - RUN: engine may be granted.
- Reset state: WAIT, frame count 0.
- Reset output values: `step`, `gen_busy`, `eng_gnt`, `eng_rvalid`, `disp_data`, `ram_we` all 0; `ram_addr` = `disp_addr`.
- Vblank edge: `vblank_q` register, reset 0. Rise = `vblank & ~vblank_q`.
- In WAIT, each rise increments the 8-bit count.
- Generation start: a rise with count == `GEN_FRAMES-1` clears the count, moves the FSM to RUN and pulses `step` in the next cycle. With `GEN_FRAMES=1`, every rise starts a generation.
- In RUN: rises are ignored and the count holds at 0. `eng_done` returns the FSM to WAIT. `eng_done` outside RUN is ignored.
- Grant (combinational): `eng_gnt = RUN & eng_req & ~disp_active`.
  - Display wins any same-cycle conflict.
  - Engine holds `eng_req`, `eng_we`, `eng_addr` and `eng_wdata` stable until granted.
- RAM mux:
  - When granted: `ram_addr`, `ram_we`, `ram_wdata` come from the engine.
  - Otherwise: `ram_addr` = `disp_addr` and `ram_we` = 0.
  - Ungranted engine writes never reach the RAM.
- Owner tag: registered, values DISP, ENGRD, NONE.
  - Cycle after a DISP access: `disp_data <= ram_rdata`. Otherwise `disp_data` holds.
  - Cycle after a granted read (ENGRD): `eng_rdata = ram_rdata`, `eng_rvalid = 1`.
  - Granted writes produce no `eng_rvalid`.
- `eng_done` in the same cycle as a grant: that access completes, including a read's `eng_rvalid` in the next cycle, then WAIT.
- `rst` mid-RUN: the FSM returns to WAIT and the count to 0 immediately. The pending `eng_rvalid` is dropped.

## Timing
- `step`: asserted 1 cycle after the qualifying vblank rise, 1 cycle wide.
- `gen_busy`: rises with `step`; falls 1 cycle after `eng_done`.
- Grant: 0-cycle latency from `eng_req` when the display is idle.
- Read latency: 1 cycle from grant to `eng_rvalid`.
- Display: `disp_data` updates 2 cycles after `disp_addr` is presented (RAM cycle + register).
- Throughput: back-to-back engine grants every cycle while `disp_active` is low.

## Configuration
- `CELLRAM_PAUSE_EN`: when defined, adds input `pause` (1 bit).
  - With `pause` high in WAIT, vblank rises are not counted and no `step` is issued.
  - A generation already in RUN finishes normally.
- Without the macro there is no `pause` port; generations run unconditionally every `GEN_FRAMES` frames.

## Test plan
- Reset: `rst` high mid-RUN with an engine read granted -> next cycle `gen_busy=0`, `eng_rvalid=0`, `step=0`; FSM counts afresh from 0.
- Pacing: `GEN_FRAMES=3`, 7 vblank rises with `eng_done` sent 10 cycles after each `step` -> `step` exactly after rises 3 and 6, each 1 cycle wide.
- Conflict: in RUN, `eng_req=1`, `disp_active=1` for 5 cycles -> `eng_gnt=0` and `ram_addr=disp_addr` throughout. `disp_active` drops -> `eng_gnt=1` that same cycle.
- Engine read: RAM[0x041]=1, granted read at 0x041 -> next cycle `eng_rvalid=1`, `eng_rdata=1`. A granted write of 0 to 0x041 -> no `eng_rvalid`; a later display read of 0x041 -> `disp_data=0`.
- Guarding: engine write while in WAIT -> `eng_gnt=0`, `ram_we=0`, RAM unchanged. `eng_done` in the same cycle as a granted read -> `eng_rvalid` still pulses; FSM in WAIT after.
- Pause (`CELLRAM_PAUSE_EN`): `pause=1` across 5 rises, then 0 -> no `step` while paused; the count resumes from its held value.

Source files
------------

// File: rtl/cellram_arbiter.sv
// cellram_arbiter: paces Life generations off vblank and arbitrates the 64x64x1 cell RAM
//   between the pixel reader (absolute priority) and the generation engine.
// Latency: grant is combinational; engine read data 1 cycle after grant; disp_data 2 cycles after disp_addr.
// Backpressure: engine holds its request stable until eng_gnt; display is never stalled.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   vblank                          vertical blanking flag (rising edges counted as frames)
//   disp_active/disp_addr/disp_data pixel reader side, disp_data registered
//   eng_req/we/addr/wdata/done      engine request side; eng_done ends a generation
//   eng_gnt/eng_rdata/eng_rvalid    engine response side
//   step, gen_busy                  generation start pulse, generation-in-progress flag
//   ram_addr/we/wdata/rdata         single-port RAM macro, 1-cycle synchronous read
//   pause                           only with CELLRAM_PAUSE_EN: freezes frame counting in WAIT
// Optional feature macro: CELLRAM_PAUSE_EN
module cellram_arbiter #(
  parameter int GEN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CELLRAM_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        vblank,
  input  logic        disp_active,
  input  logic [11:0] disp_addr,
  output logic        disp_data,
  input  logic        eng_req,
  input  logic        eng_we,
  input  logic [11:0] eng_addr,
  input  logic        eng_wdata,
  input  logic        eng_done,
  output logic        eng_gnt,
  output logic        eng_rdata,
  output logic        eng_rvalid,
  output logic        step,
  output logic        gen_busy,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic        ram_wdata,
  input  logic        ram_rdata
);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Who issued the RAM access in the previous cycle, i.e. who owns ram_rdata now.
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_DISP  = 2'd1;
  localparam logic [1:0] OWN_ENGRD = 2'd2;

  localparam logic [7:0] LAST_FRAME = 8'(GEN_FRAMES - 1);

  logic [0:0] state;
  logic [7:0] frame_cnt;
  logic       vblank_q;
  logic [1:0] owner;
  logic       rise;
  logic       count_en;

`ifdef CELLRAM_PAUSE_EN
  assign count_en = ~pause;
`else
  assign count_en = 1'b1;
`endif

  assign rise     = vblank & ~vblank_q;
  assign gen_busy = (state == S_RUN);

  // Display wins any same-cycle conflict; the engine simply retries next cycle.
  assign eng_gnt  = gen_busy & eng_req & ~disp_active;

  // Ungranted engine writes are masked here so they never reach the macro.
  assign ram_addr  = eng_gnt ? eng_addr : disp_addr;
  assign ram_we    = eng_gnt & eng_we;
  assign ram_wdata = eng_gnt & eng_wdata;

  assign eng_rdata  = ram_rdata;
  assign eng_rvalid = (owner == OWN_ENGRD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      frame_cnt <= 8'd0;
      vblank_q  <= 1'b0;
      step      <= 1'b0;
      owner     <= OWN_NONE;
      disp_data <= 1'b0;
    end else begin
      vblank_q <= vblank;
      step     <= 1'b0;

      case (state)
        S_WAIT: begin
          if (rise && count_en) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= 8'd0;
              state     <= S_RUN;
              step      <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          // Rises during a generation are dropped, not banked.
          frame_cnt <= 8'd0;
          if (eng_done) state <= S_WAIT;
        end
      endcase

      // A grant issued together with eng_done still completes its read next cycle.
      if (eng_gnt && !eng_we)
        owner <= OWN_ENGRD;
      else if (disp_active)
        owner <= OWN_DISP;
      else
        owner <= OWN_NONE;

      if (owner == OWN_DISP) disp_data <= ram_rdata;
    end
  end

endmodule
